// File: rtl/rr8_pkt_mux.sv
// rr8_pkt_mux: locks onto the arbiter's winner for a whole packet and forwards beats through a registered output stage
module rr8_pkt_mux #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_valid,
    input  logic [8*DW-1:0] in_data,
    input  logic [7:0]      in_last,
    output logic [7:0]      in_ready,
    output logic [7:0]      arb_req,
    input  logic [7:0]      arb_gnt,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [2:0]      out_src,
    input  logic            out_ready,
    output logic            busy,
    output logic            err_gnt
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, next_state;
    logic [2:0] sel, gnt_idx;
    logic gnt_legal, gnt_bad, can_load, accept;
    // grant legality: exactly one bit, and only on a source that is requesting
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < 8; i++)
            if (arb_gnt[i]) gnt_idx = 3'(i);
        gnt_legal = (arb_gnt != '0) && ((arb_gnt & (arb_gnt - 8'd1)) == '0) && ((arb_gnt & ~in_valid) == '0);
        gnt_bad = (arb_gnt != '0) && !gnt_legal;
        can_load = ~out_valid | out_ready;
        accept = (state == LOCK) && in_valid[sel] && can_load;
    end
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next_state;
    end
    // next state: leave IDLE on a legal grant, leave LOCK after the last beat is taken
    always_comb begin
        next_state = state;
        if (state == IDLE) next_state = gnt_legal ? LOCK : IDLE;
        else next_state = (accept && in_last[sel]) ? IDLE : LOCK;
    end
    // outputs: request only while idle so the arbiter pointer stays frozen mid-packet
    always_comb begin
        arb_req = (state == IDLE) ? in_valid : '0;
        in_ready = (state == LOCK && can_load) ? (8'h01 << sel) : '0;
        busy = (state == LOCK);
    end
    // winner capture, output register and illegal-grant pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_src <= '0;
            err_gnt <= 1'b0;
        end else begin
            if (state == IDLE && gnt_legal) sel <= gnt_idx;
            err_gnt <= (state == IDLE) && gnt_bad;
            if (accept) begin
                out_valid <= 1'b1;
                out_data <= in_data[sel*DW +: DW];
                out_last <= in_last[sel];
                out_src <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
